wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 34 +++
 rtl/wb_arbiter_if.sv | 38 +++
 rtl/wb_timeout_ctr.sv | 32 +++
 rtl/wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master register-bus arbiter:
// FSM encodings, master indices, bus widths and the grant-selection helper.
package wb_arbiter_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUS  = 2'd1;
  localparam logic [1:0] ARB_RET  = 2'd2;

  localparam logic M_SPI  = 1'b0;
  localparam logic M_MIDI = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  // A lone requester always wins; a tie goes to the round-robin pointer.
  function automatic logic pick_master(input logic ptr, input logic stb0, input logic stb1);
    logic sel;
    if (stb0 && stb1) begin
      sel = ptr;
    end else if (stb1) begin
      sel = M_MIDI;
    end else begin
      sel = M_SPI;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the two master request ports and the shared register-bus port.
// 'slave' is the arbiter's view (it serves the masters and drives the bus);
// 'master' is the environment's view (requesting masters plus bus slave).
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic              m0_stb_i,  m1_stb_i;
  logic              m0_we_i,   m1_we_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [DATA_W-1:0] m0_data_i, m1_data_i;
  logic              m0_ack_o,  m1_ack_o;
  logic              m0_err_o,  m1_err_o;
  logic [DATA_W-1:0] m0_data_o, m1_data_o;

  logic              s_stb_o;
  logic              s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_data_o;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ack_i;

  modport slave (
    input  m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
    input  m0_addr_i, m1_addr_i, m0_data_i, m1_data_i,
    output m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_data_o, m1_data_o,
    output s_stb_o, s_we_o, s_addr_o, s_data_o,
    input  s_data_i, s_ack_i
  );

  modport master (
    output m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
    output m0_addr_i, m1_addr_i, m0_data_i, m1_data_i,
    input  m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_data_o, m1_data_o,
    input  s_stb_o, s_we_o, s_addr_o, s_data_o,
    output s_data_i, s_ack_i
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled clocks since the last clear and flags
// expiry during the LIMIT-th enabled clock, so the owner can abort on that edge.
module wb_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles, saturating at the expiry value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CW'(LIMIT - 1))) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = i_enable && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter onto a single register bus.
// Optional feature: define WB_ARB_TIMEOUT_EN to abort unacknowledged bus
// cycles after TIMEOUT_CYCLES clocks with an error pulse to the owner.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  logic [1:0]        r_state;
  logic              r_ptr;
  logic              r_gnt;
  logic              r_s_stb;
  logic              r_s_we;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_data;
  logic              r_m0_ack, r_m1_ack;
  logic              r_m0_err, r_m1_err;
  logic [DATA_W-1:0] r_m0_data, r_m1_data;

  logic              w_any_stb;
  logic              w_gnt;
  req_t              w_req;
  logic              w_timeout;

  assign w_any_stb = bus.m0_stb_i | bus.m1_stb_i;
  assign w_gnt     = pick_master(r_ptr, bus.m0_stb_i, bus.m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  wb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state != ARB_BUS),
    .i_enable  (r_state == ARB_BUS),
    .o_expired (w_timeout)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_timeout    = 1'b0;
`endif

  // Select the request fields of whichever master would be granted now.
  always_comb begin
    w_req = '0;
    if (w_gnt == M_MIDI) begin
      w_req = '{we: bus.m1_we_i, addr: bus.m1_addr_i, data: bus.m1_data_i};
    end else begin
      w_req = '{we: bus.m0_we_i, addr: bus.m0_addr_i, data: bus.m0_data_i};
    end
  end

  // Arbitration FSM: grant, hold the bus frozen, complete (ack or timeout), one-cycle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= M_SPI;
      r_gnt     <= M_SPI;
      r_s_stb   <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_addr  <= 7'h00;
      r_s_data  <= 8'h00;
      r_m0_ack  <= 1'b0;
      r_m1_ack  <= 1'b0;
      r_m0_err  <= 1'b0;
      r_m1_err  <= 1'b0;
      r_m0_data <= 8'h00;
      r_m1_data <= 8'h00;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_stb) begin
            r_gnt    <= w_gnt;
            r_s_we   <= w_req.we;
            r_s_addr <= w_req.addr;
            r_s_data <= w_req.data;
            r_s_stb  <= 1'b1;
            r_state  <= ARB_BUS;
          end else begin
            r_state  <= ARB_IDLE;
          end
        end
        ARB_BUS: begin
          // Ack wins over a simultaneous timeout.
          if (bus.s_ack_i) begin
            r_s_stb <= 1'b0;
            r_ptr   <= ~r_ptr;
            r_state <= ARB_RET;
            if (r_gnt == M_MIDI) begin
              r_m1_ack <= 1'b1;
              if (!r_s_we) begin
                r_m1_data <= bus.s_data_i;
              end else begin
                r_m1_data <= r_m1_data;
              end
            end else begin
              r_m0_ack <= 1'b1;
              if (!r_s_we) begin
                r_m0_data <= bus.s_data_i;
              end else begin
                r_m0_data <= r_m0_data;
              end
            end
          end else if (w_timeout) begin
            r_s_stb <= 1'b0;
            r_ptr   <= ~r_ptr;
            r_state <= ARB_RET;
            if (r_gnt == M_MIDI) begin
              r_m1_err <= 1'b1;
            end else begin
              r_m0_err <= 1'b1;
            end
          end else begin
            r_state <= ARB_BUS;
          end
        end
        ARB_RET: begin
          r_state <= ARB_IDLE;
        end
        default: begin
          r_s_stb <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.s_stb_o   = r_s_stb;
  assign bus.s_we_o    = r_s_we;
  assign bus.s_addr_o  = r_s_addr;
  assign bus.s_data_o  = r_s_data;
  assign bus.m0_ack_o  = r_m0_ack;
  assign bus.m1_ack_o  = r_m1_ack;
  assign bus.m0_err_o  = r_m0_err;
  assign bus.m1_err_o  = r_m1_err;
  assign bus.m0_data_o = r_m0_data;
  assign bus.m1_data_o = r_m1_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default and WB_ARB_TIMEOUT_EN builds).
module tb_wb_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   ack0_cnt = 0, ack1_cnt = 0, err0_cnt = 0, err1_cnt = 0;

  wb_arbiter_if bus();

  wb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters: outputs sampled before the edge updates them.
  always @(posedge clk) begin
    if (bus.m0_ack_o === 1'b1) ack0_cnt++;
    if (bus.m1_ack_o === 1'b1) ack1_cnt++;
    if (bus.m0_err_o === 1'b1) err0_cnt++;
    if (bus.m1_err_o === 1'b1) err1_cnt++;
  end

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.m0_stb_i = 1'b0; bus.m1_stb_i = 1'b0;
    bus.m0_we_i  = 1'b0; bus.m1_we_i  = 1'b0;
    bus.m0_addr_i = 7'h00; bus.m1_addr_i = 7'h00;
    bus.m0_data_i = 8'h00; bus.m1_data_i = 8'h00;
    bus.s_ack_i  = 1'b0; bus.s_data_i = 8'h00;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.s_stb_o === 1'b1) ok = 1'b1;
    end
  endtask

  // Acts as the bus slave: acks 'lat' edges after the strobe appears.
  // Returns on the negedge where the resulting ack pulse is visible.
  task automatic slave_serve(input int lat, input logic [7:0] rdata,
                             output logic [6:0] addr_seen, output logic we_seen, output bit ok);
    addr_seen = 7'h00;
    we_seen   = 1'b0;
    wait_stb(ok);
    if (ok) begin
      addr_seen = bus.s_addr_o;
      we_seen   = bus.s_we_o;
      repeat (lat - 1) @(negedge clk);
      bus.s_ack_i = 1'b1; bus.s_data_i = rdata;
      @(negedge clk);
      bus.s_ack_i = 1'b0; bus.s_data_i = 8'h00;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o} !== 17'h00000) begin
      errors++;
      $display("FAIL reset_bus: got %h want 00000", {bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o});
    end
    checks++;
    if ({bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 0000", {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o});
    end
    checks++;
    if ({bus.m0_data_o, bus.m1_data_o} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata: got %h want 0000", {bus.m0_data_o, bus.m1_data_o});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.s_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_stb: got %b want 0", bus.s_stb_o);
    end
  endtask

  task automatic test_write();
    int b0, b1;
    b0 = ack0_cnt; b1 = ack1_cnt;
    bus.m0_stb_i = 1'b1; bus.m0_we_i = 1'b1; bus.m0_addr_i = 7'h12; bus.m0_data_i = 8'hA5;
    @(negedge clk);
    checks++;
    if ({bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o} !== {1'b1, 1'b1, 7'h12, 8'hA5}) begin
      errors++;
      $display("FAIL write_strobe: got %h want %h", {bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o}, {1'b1, 1'b1, 7'h12, 8'hA5});
    end
    bus.m0_we_i = 1'b0; bus.m0_addr_i = 7'h7F; bus.m0_data_i = 8'hFF;
    @(negedge clk);
    checks++;
    if ({bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o} !== {1'b1, 1'b1, 7'h12, 8'hA5}) begin
      errors++;
      $display("FAIL write_hold: got %h want %h", {bus.s_stb_o, bus.s_we_o, bus.s_addr_o, bus.s_data_o}, {1'b1, 1'b1, 7'h12, 8'hA5});
    end
    bus.s_ack_i = 1'b1; bus.m0_stb_i = 1'b0;
    @(negedge clk);
    bus.s_ack_i = 1'b0;
    checks++;
    if ({bus.m0_ack_o, bus.m1_ack_o, bus.s_stb_o} !== 3'b100) begin
      errors++;
      $display("FAIL write_ack: got %b want 100", {bus.m0_ack_o, bus.m1_ack_o, bus.s_stb_o});
    end
    @(negedge clk);
    checks++;
    if (bus.m0_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL write_ack_width: got %b want 0", bus.m0_ack_o);
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ((ack0_cnt - b0) != 1 || (ack1_cnt - b1) != 0) begin
      errors++;
      $display("FAIL write_ack_count: got m0=%0d m1=%0d want m0=1 m1=0", ack0_cnt - b0, ack1_cnt - b1);
    end
  endtask

  task automatic test_read();
    logic [6:0] a; logic w; bit ok;
    bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 7'h05; bus.m1_data_i = 8'h99;
    slave_serve(1, 8'h3C, a, w, ok);
    bus.m1_stb_i = 1'b0;
    checks++;
    if ({ok, a, w} !== {1'b1, 7'h05, 1'b0}) begin
      errors++;
      $display("FAIL read_request: got ok=%b addr=%h we=%b want ok=1 addr=05 we=0", ok, a, w);
    end
    checks++;
    if ({bus.m1_ack_o, bus.m1_data_o, bus.m0_ack_o} !== {1'b1, 8'h3C, 1'b0}) begin
      errors++;
      $display("FAIL read_ack: got %h want %h", {bus.m1_ack_o, bus.m1_data_o, bus.m0_ack_o}, {1'b1, 8'h3C, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({bus.m1_ack_o, bus.m1_data_o, bus.m0_data_o} !== {1'b0, 8'h3C, 8'h00}) begin
      errors++;
      $display("FAIL read_hold: got %h want %h", {bus.m1_ack_o, bus.m1_data_o, bus.m0_data_o}, {1'b0, 8'h3C, 8'h00});
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack_outside();
    int b0, b1;
    b0 = ack0_cnt; b1 = ack1_cnt;
    bus.s_ack_i = 1'b1; bus.s_data_i = 8'hEE;
    repeat (3) @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ((ack0_cnt - b0) != 0 || (ack1_cnt - b1) != 0 || bus.m1_data_o !== 8'h3C || bus.s_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: got acks=%0d/%0d m1_data=%h stb=%b want 0/0 3C 0",
               ack0_cnt - b0, ack1_cnt - b1, bus.m1_data_o, bus.s_stb_o);
    end
  endtask

  task automatic test_alternate();
    logic [6:0] exp_addr [4];
    logic [6:0] a; logic w; bit ok;
    int b0, b1;
    exp_addr[0] = 7'h10; exp_addr[1] = 7'h20; exp_addr[2] = 7'h10; exp_addr[3] = 7'h20;
    @(negedge clk);
    rst_n = 1'b0;
    bus.m0_stb_i = 1'b1; bus.m0_addr_i = 7'h10;
    bus.m1_stb_i = 1'b1; bus.m1_addr_i = 7'h20;
    repeat (2) @(negedge clk);
    b0 = ack0_cnt; b1 = ack1_cnt;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slave_serve(1, 8'h40 + 8'(i), a, w, ok);
      checks++;
      if (!ok || a !== exp_addr[i]) begin
        errors++;
        $display("FAIL rr_grant_%0d: got ok=%b addr=%h want addr=%h", i, ok, a, exp_addr[i]);
      end
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    checks++;
    if ((ack0_cnt - b0) != 2 || (ack1_cnt - b1) != 2 || bus.m0_data_o !== 8'h42 || bus.m1_data_o !== 8'h43) begin
      errors++;
      $display("FAIL rr_totals: got acks=%0d/%0d data=%h/%h want 2/2 42/43",
               ack0_cnt - b0, ack1_cnt - b1, bus.m0_data_o, bus.m1_data_o);
    end
  endtask

  task automatic test_timeout();
    int b0, b1, e0, e1, n_high;
    logic [6:0] a; logic w; bit ok;
    b0 = ack0_cnt; b1 = ack1_cnt; e0 = err0_cnt; e1 = err1_cnt; n_high = 0;
    bus.m0_stb_i = 1'b1; bus.m0_we_i = 1'b1; bus.m0_addr_i = 7'h33;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.s_stb_o === 1'b1) begin
        n_high++;
        bus.m0_stb_i = 1'b0;
      end
    end
`ifdef WB_ARB_TIMEOUT_EN
    checks++;
    if (n_high != 16) begin
      errors++;
      $display("FAIL timeout_len: got %0d want 16", n_high);
    end
    checks++;
    if ((err0_cnt - e0) != 1 || (err1_cnt - e1) != 0 || (ack0_cnt - b0) != 0 || (ack1_cnt - b1) != 0) begin
      errors++;
      $display("FAIL timeout_pulses: got err=%0d/%0d ack=%0d/%0d want 1/0 0/0",
               err0_cnt - e0, err1_cnt - e1, ack0_cnt - b0, ack1_cnt - b1);
    end
`else
    checks++;
    if (n_high != 40) begin
      errors++;
      $display("FAIL no_timeout_len: got %0d want 40", n_high);
    end
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    bus.s_ack_i = 1'b0;
    checks++;
    if ((err0_cnt - e0) != 0 || (err1_cnt - e1) != 0 || bus.m0_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL late_ack: got err=%0d/%0d ack=%b want 0/0 1", err0_cnt - e0, err1_cnt - e1, bus.m0_ack_o);
    end
`endif
    idle_inputs();
    repeat (2) @(negedge clk);
    bus.m1_stb_i = 1'b1; bus.m1_addr_i = 7'h2A;
    slave_serve(1, 8'h77, a, w, ok);
    bus.m1_stb_i = 1'b0;
    checks++;
    if (!ok || a !== 7'h2A || bus.m1_ack_o !== 1'b1 || bus.m1_data_o !== 8'h77) begin
      errors++;
      $display("FAIL after_timeout: got ok=%b addr=%h ack=%b data=%h want 1 2A 1 77", ok, a, bus.m1_ack_o, bus.m1_data_o);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int b0, b1, e0, e1;
    logic [6:0] a; logic w; bit ok;
    b0 = ack0_cnt; b1 = ack1_cnt; e0 = err0_cnt; e1 = err1_cnt;
    bus.m1_stb_i = 1'b1; bus.m1_addr_i = 7'h44;
    wait_stb(ok);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || bus.s_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stb: got ok=%b stb=%b want 1 0", ok, bus.s_stb_o);
    end
    bus.m0_stb_i = 1'b1; bus.m0_addr_i = 7'h10;
    bus.m1_stb_i = 1'b1; bus.m1_addr_i = 7'h20;
    repeat (2) @(negedge clk);
    checks++;
    if ((ack0_cnt - b0) != 0 || (ack1_cnt - b1) != 0 || (err0_cnt - e0) != 0 || (err1_cnt - e1) != 0
        || bus.m1_data_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_quiet: got ack=%0d/%0d err=%0d/%0d m1_data=%h want 0/0 0/0 00",
               ack0_cnt - b0, ack1_cnt - b1, err0_cnt - e0, err1_cnt - e1, bus.m1_data_o);
    end
    rst_n = 1'b1;
    slave_serve(1, 8'h11, a, w, ok);
    checks++;
    if (!ok || a !== 7'h10) begin
      errors++;
      $display("FAIL reset_mid_first: got ok=%b addr=%h want addr=10", ok, a);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_stb();
    logic [6:0] a; logic w; bit ok;
    apply_reset();
    bus.m0_stb_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 7'h55;
    wait_stb(ok);
    bus.m0_stb_i = 1'b0;
    @(negedge clk);
    bus.s_ack_i = 1'b1; bus.s_data_i = 8'h5A;
    @(negedge clk);
    bus.s_ack_i = 1'b0; bus.s_data_i = 8'h00;
    checks++;
    if (!ok || bus.m0_ack_o !== 1'b1 || bus.m0_data_o !== 8'h5A) begin
      errors++;
      $display("FAIL drop_ack: got ok=%b ack=%b data=%h want 1 1 5A", ok, bus.m0_ack_o, bus.m0_data_o);
    end
    repeat (2) @(negedge clk);
    bus.m0_stb_i = 1'b1; bus.m0_addr_i = 7'h10;
    bus.m1_stb_i = 1'b1; bus.m1_addr_i = 7'h20;
    slave_serve(1, 8'h22, a, w, ok);
    checks++;
    if (!ok || a !== 7'h20) begin
      errors++;
      $display("FAIL drop_ptr_flip: got ok=%b addr=%h want addr=20", ok, a);
    end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_ack_outside();
    test_alternate();
    test_timeout();
    test_reset_mid();
    test_drop_stb();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
